gate_bist: RTL

Synthesizable on-chip truth-table checker for small combinational gates such as implication and non-implication. On `start` it steps the gate under test through every input vector in ascending order. For each vector it waits a settle window, samples the gate output, and compares it with a latched expected truth table. It stops at the first mismatch and reports pass/fail, the first failing index and the captured table. It sits beside the gate under test on the board and drives the gate's inputs directly.

---
 rtl/gate_bist_if.sv | 27 ++
 rtl/gate_bist.sv | 134 +++++++++++++
 2 files changed

// File: rtl/gate_bist_if.sv
// Connection bundle between gate_bist, the gate under test, and the controlling host.
// The slave side is the checker; the master side is whoever drives start/expected and the gate.
interface gate_bist_if #(
  parameter int N_IN = 2
);
  localparam int V = 1 << N_IN;

  logic            start;
  logic [V-1:0]    expected;
  logic [N_IN-1:0] dut_in;
  logic            dut_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN-1:0] fail_idx;
  logic [V-1:0]    got;

  modport master (
    output start, expected, dut_out,
    input  dut_in, busy, done, pass, fail_idx, got
  );

  modport slave (
    input  start, expected, dut_out,
    output dut_in, busy, done, pass, fail_idx, got
  );
endinterface

// File: rtl/gate_bist.sv
// Exhaustive truth-table checker for a small combinational gate: walks all 2^N_IN vectors,
// holds each for SETTLE_CYCLES, samples the response and stops at the first mismatch.
module gate_bist #(
  parameter int N_IN          = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input logic       clk,
  input logic       rst_n,
  gate_bist_if.slave bus
);
  localparam int V  = 1 << N_IN;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_APPLY = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]      state_q,    state_d;
  logic [N_IN-1:0] idx_q,      idx_d;
  logic [CW-1:0]   cnt_q,      cnt_d;
  logic [V-1:0]    exp_q,      exp_d;
  logic [V-1:0]    got_q,      got_d;
  logic            pass_q,     pass_d;
  logic [N_IN-1:0] fail_idx_q, fail_idx_d;
  logic            busy_q,     busy_d;
  logic            done_q,     done_d;
  logic [N_IN-1:0] dut_in_q,   dut_in_d;

  // Next-state, result capture and registered-output decode.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    exp_d      = exp_q;
    got_d      = got_q;
    pass_d     = pass_q;
    fail_idx_d = fail_idx_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    dut_in_d   = {N_IN{1'b0}};

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d    = ST_APPLY;
          exp_d      = bus.expected;
          got_d      = {V{1'b0}};
          pass_d     = 1'b0;
          fail_idx_d = {N_IN{1'b0}};
          idx_d      = {N_IN{1'b0}};
          cnt_d      = {CW{1'b0}};
          busy_d     = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_APPLY: begin
        busy_d   = 1'b1;
        dut_in_d = idx_q;
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          // End of the settle window: the next vector appears on this same edge.
          got_d[idx_q] = bus.dut_out;
          if (bus.dut_out != exp_q[idx_q]) begin
            fail_idx_d = idx_q;
            pass_d     = 1'b0;
            state_d    = ST_DONE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            dut_in_d   = {N_IN{1'b0}};
          end else if (idx_q == IDX_LAST) begin
            fail_idx_d = {N_IN{1'b0}};
            pass_d     = 1'b1;
            state_d    = ST_DONE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            dut_in_d   = {N_IN{1'b0}};
          end else begin
            idx_d    = idx_q + N_IN'(1);
            cnt_d    = {CW{1'b0}};
            dut_in_d = idx_q + N_IN'(1);
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; an async reset aborts a run and clears all results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= {N_IN{1'b0}};
      cnt_q      <= {CW{1'b0}};
      exp_q      <= {V{1'b0}};
      got_q      <= {V{1'b0}};
      pass_q     <= 1'b0;
      fail_idx_q <= {N_IN{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dut_in_q   <= {N_IN{1'b0}};
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      exp_q      <= exp_d;
      got_q      <= got_d;
      pass_q     <= pass_d;
      fail_idx_q <= fail_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dut_in_q   <= dut_in_d;
    end
  end

  assign bus.dut_in   = dut_in_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.fail_idx = fail_idx_q;
  assign bus.got      = got_q;
endmodule
